fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_reader_skid.sv | 55 +++++
 rtl/fifo_reader.sv | 106 ++++++++++
 tb/tb_fifo_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, FSM state type and helpers for the FIFO burst reader.
package fifo_pkg;

    localparam int DATA_W    = 8;
    localparam int BURST_MAX = 15;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // A burst request is usable only for lengths 1..max_len.
    function automatic logic len_legal(input logic [CNT_W-1:0] len, input int max_len);
        return (len != '0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order buffer that holds FIFO read data until the stream side takes it.
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int DATA_W = fifo_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occupancy
);

    logic [1:0][DATA_W-1:0] w_entry;
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DATA_W-1:0] r_data;

            // Each slot loads only when the write pointer selects it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= '0;
                end else if (push && (r_wr_ptr == 1'(gi))) begin
                    r_data <= push_data;
                end
            end

            assign w_entry[gi] = r_data;
        end
    endgenerate

    // Ring pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) r_wr_ptr <= ~r_wr_ptr;
            if (pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + 2'(push) - 2'(pop);
        end
    end

    assign head      = w_entry[r_rd_ptr];
    assign occupancy = r_count;

endmodule

// File: rtl/fifo_reader.sv
// Burst reader: pops a requested number of words from a registered-read FIFO
// and presents them on a valid/ready stream.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W    = fifo_pkg::DATA_W,
    parameter int BURST_MAX = fifo_pkg::BURST_MAX
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [fifo_pkg::CNT_W-1:0] burst_len,
    input  logic                       fifo_empty,
    output logic                       fifo_rd,
    input  logic [DATA_W-1:0]          fifo_dout,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic                       busy,
    output logic                       done,
    output logic [fifo_pkg::CNT_W-1:0] rd_count
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_issued;
    logic [CNT_W-1:0]   r_rd_count;
    logic               r_inflight;
    logic [1:0]         w_occ;
    logic [2:0]         w_committed;
    logic               w_accept;
    logic               w_m_valid;
    logic               w_pop;
    logic               w_rd;
    logic               w_done;

    fifo_reader_skid #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight),
        .push_data (fifo_dout),
        .pop       (w_pop),
        .head      (m_data),
        .occupancy (w_occ)
    );

    assign w_accept  = !rst && (r_state == IDLE) && start && len_legal(burst_len, BURST_MAX);
    assign w_m_valid = !rst && (w_occ != 2'd0);
    assign w_pop     = w_m_valid && m_ready;
    // Slots still claimed after this edge: a word leaving this cycle frees its
    // slot in time for a new read, which keeps the stream at one word per cycle.
    assign w_committed = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = READ;
            READ:    if ((r_issued + CNT_W'(w_rd)) == r_len) w_state_next = DRAIN;
            DRAIN:   if (w_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs: pop strobe, completion pulse and status.
    always_comb begin
        w_rd    = !rst && (r_state == READ) && !fifo_empty &&
                  (r_issued < r_len) && (w_committed < 3'd2);
        w_done  = !rst && (r_state == DRAIN) && w_pop &&
                  ((r_rd_count + CNT_W'(1)) == r_len);
        fifo_rd = w_rd;
        done    = w_done;
        busy    = (r_state != IDLE);
        m_valid = w_m_valid;
    end

    // Burst bookkeeping; the in-flight flag marks that fifo_dout is valid this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= '0;
            r_issued   <= '0;
            r_rd_count <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd;
            if (w_accept) begin
                r_len      <= burst_len;
                r_issued   <= '0;
                r_rd_count <= '0;
            end else begin
                if (w_rd)  r_issued   <= r_issued + CNT_W'(1);
                if (w_pop) r_rd_count <= r_rd_count + CNT_W'(1);
            end
        end
    end

    assign rd_count = r_rd_count;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed + randomized bench for fifo_reader against a 15-deep registered-read FIFO.
module tb_fifo_reader;
    import fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  burst_len = '0;
    logic              fifo_empty = 1'b1;
    logic              fifo_rd;
    logic [DATA_W-1:0] fifo_dout = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  rd_count;

    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       fifo_clr = 1'b0;
    logic [7:0] fifo_q[$];

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] got_q[$];
    int xfer_cyc[$];
    int cyc = 0, rd_pulses = 0, done_pulses = 0, done_bad = 0, rd_while_empty = 0;
    int hold_err = 0, max_out = 0, popped = 0, delivered = 0, out_base = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    fifo_reader dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
        .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .done(done), .rd_count(rd_count)
    );

    // Team FIFO model: 15 deep, data appears on fifo_dout the cycle after a pop.
    always @(posedge clk) begin
        if (fifo_clr) begin
            fifo_q.delete();
        end else begin
            if (fifo_rd && fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
            if (wr_en && fifo_q.size() < 15) fifo_q.push_back(wr_data);
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Stream/strobe observer, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                xfer_cyc.push_back(cyc);
                delivered++;
            end
            if (fifo_rd) begin
                rd_pulses++;
                popped++;
            end
            if (fifo_rd && fifo_empty) rd_while_empty++;
            if (done) begin
                done_pulses++;
                if (!(m_valid && m_ready)) done_bad++;
            end
            if (prev_stall && m_valid && (m_data !== prev_data)) hold_err++;
            if (popped - delivered - out_base > max_out) max_out = popped - delivered - out_base;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic fifo_push(input logic [7:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic start_burst(input logic [CNT_W-1:0] len);
        start     = 1'b1;
        burst_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int n;
        n = 0;
        while (done_pulses == d0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(done_pulses != d0), 32'd1);
        tick();
    endtask

    task automatic check_words(input string tag, input int base, input logic [7:0] exp_q[$]);
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] g;
            g = (base + i < got_q.size()) ? got_q[base + i] : 8'hxx;
            check($sformatf("%s[%0d]", tag, i), 32'(g), 32'(exp_q[i]));
        end
        check({tag, "_count"}, 32'(got_q.size() - base), 32'(exp_q.size()));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fifo_rd"},  32'(fifo_rd),  32'd0);
        check({tag, "_m_valid"},  32'(m_valid),  32'd0);
        check({tag, "_m_data"},   32'(m_data),   32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_rd_count"}, 32'(rd_count), 32'd0);
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] snap_q[$];
    int base, d0, r0, h0, e0, db0, n, span;

    initial begin
        // Reset state
        rst = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Five preloaded words, sink always ready: back-to-back delivery
        m_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h11 + i));
        foreach (exp_q[i]) fifo_push(exp_q[i]);
        tick(2);
        base = got_q.size();
        d0   = done_pulses;
        start_burst(5);
        wait_done("t1_done_seen", d0, 60);
        check_words("t1_word", base, exp_q);
        span = (got_q.size() >= base + 5) ? (xfer_cyc[base + 4] - xfer_cyc[base]) : -1;
        check("t1_consecutive_span", 32'(span), 32'd4);
        check("t1_done_pulses", 32'(done_pulses - d0), 32'd1);
        check("t1_rd_count", 32'(rd_count), 32'd5);
        check("t1_busy_after", 32'(busy), 32'd0);
        $display("t1: burst of 5 complete");

        // Sink stalled for 10 cycles: only two words may be fetched
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        foreach (exp_q[i]) fifo_push(exp_q[i]);
        tick(2);
        m_ready = 1'b0;
        base = got_q.size();
        r0   = rd_pulses;
        h0   = hold_err;
        d0   = done_pulses;
        start_burst(4);
        tick(10);
        check("t2_rd_during_stall", 32'(rd_pulses - r0), 32'd2);
        check("t2_no_xfer_during_stall", 32'(got_q.size() - base), 32'd0);
        check("t2_valid_during_stall", 32'(m_valid), 32'd1);
        check("t2_head_during_stall", 32'(m_data), 32'(exp_q[0]));
        m_ready = 1'b1;
        wait_done("t2_done_seen", d0, 60);
        check_words("t2_word", base, exp_q);
        check("t2_hold_errors", 32'(hold_err - h0), 32'd0);
        $display("t2: stalled burst of 4 complete");

        // FIFO runs dry mid-burst, refilled 6 cycles later
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        fifo_push(exp_q[0]);
        fifo_push(exp_q[1]);
        tick(2);
        base = got_q.size();
        e0   = rd_while_empty;
        r0   = rd_pulses;
        d0   = done_pulses;
        start_burst(4);
        tick(6);
        check("t3_rd_before_refill", 32'(rd_pulses - r0), 32'd2);
        fifo_push(exp_q[2]);
        fifo_push(exp_q[3]);
        wait_done("t3_done_seen", d0, 60);
        check_words("t3_word", base, exp_q);
        check("t3_rd_while_empty", 32'(rd_while_empty - e0), 32'd0);
        check("t3_fifo_left", 32'(fifo_q.size()), 32'd0);
        $display("t3: underrun burst of 4 complete");

        // Illegal lengths and a start while busy are ignored
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        foreach (exp_q[i]) fifo_push(exp_q[i]);
        tick(2);
        base = got_q.size();
        d0   = done_pulses;
        start_burst(0);
        tick();
        check("t4_len0_busy", 32'(busy), 32'd0);
        check("t4_len0_fifo_count", 32'(fifo_q.size()), 32'd3);
        start_burst(20);
        tick();
        check("t4_len20_busy", 32'(busy), 32'd0);
        check("t4_len20_fifo_count", 32'(fifo_q.size()), 32'd3);
        m_ready = 1'b0;
        start_burst(3);
        check("t4_busy_after_start", 32'(busy), 32'd1);
        start_burst(2);
        check("t4_busy_after_restart", 32'(busy), 32'd1);
        m_ready = 1'b1;
        wait_done("t4_done_seen", d0, 60);
        tick(3);
        check_words("t4_word", base, exp_q);
        check("t4_rd_count", 32'(rd_count), 32'd3);
        check("t4_busy_idle", 32'(busy), 32'd0);
        check("t4_done_pulses", 32'(done_pulses - d0), 32'd1);
        $display("t4: ignored starts handled");

        // Reset after two of eight words, then a fresh burst of 3
        exp_q.delete();
        for (int i = 0; i < 11; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        foreach (exp_q[i]) fifo_push(exp_q[i]);
        tick(2);
        base = got_q.size();
        start_burst(8);
        n = 0;
        while (got_q.size() - base < 2 && n < 40) begin
            tick();
            n++;
        end
        check("t5_two_delivered", 32'(got_q.size() - base), 32'd2);
        check("t5_first_word", 32'(got_q[base]), 32'(exp_q[0]));
        rst = 1'b1;
        tick();
        check_reset_outputs("t5_reset");
        out_base = popped - delivered;
        rst = 1'b0;
        snap_q.delete();
        for (int i = 0; i < 3; i++) snap_q.push_back(fifo_q[i]);
        tick();
        base = got_q.size();
        d0   = done_pulses;
        start_burst(3);
        wait_done("t5_done_seen", d0, 60);
        check_words("t5_word", base, snap_q);
        $display("t5: reset mid-burst and restart complete");

        // Full FIFO, maximum burst, random back-pressure
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 15; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        foreach (exp_q[i]) fifo_push(exp_q[i]);
        tick(2);
        check("t6_fifo_full", 32'(fifo_q.size()), 32'd15);
        base = got_q.size();
        d0   = done_pulses;
        db0  = done_bad;
        start_burst(15);
        n = 0;
        while (done_pulses == d0 && n < 600) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        m_ready = 1'b1;
        check("t6_done_seen", 32'(done_pulses != d0), 32'd1);
        tick(3);
        check_words("t6_word", base, exp_q);
        check("t6_fifo_empty", 32'(fifo_q.size()), 32'd0);
        check("t6_done_pulses", 32'(done_pulses - d0), 32'd1);
        check("t6_done_misplaced", 32'(done_bad - db0), 32'd0);
        check("t6_busy_idle", 32'(busy), 32'd0);
        $display("t6: burst of 15 with random ready complete");

        // Whole-run invariants
        check("all_rd_while_empty", 32'(rd_while_empty), 32'd0);
        check("all_outstanding_le2", 32'(max_out <= 2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
